// File: rtl/cache_mem_responder_pkg.sv
// Shared widths and responder state encoding for the cache memory-port interface.
package cache_mem_responder_pkg;

  localparam int unsigned CM_ADR_WIDTH   = 32;
  localparam int unsigned CM_DATA_WIDTH  = 32;
  localparam int unsigned CM_WORD_OFFSET = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_BEAT,
    S_GAP,
    S_DONE
  } state_t;

endpackage

// File: rtl/cache_mem_array.sv
// Single-port synchronous RAM with write enable and reset-clearable registered read port.
module cache_mem_array
  import cache_mem_responder_pkg::*;
#(
  parameter int unsigned ADR_BITS   = 10,
  parameter int unsigned DATA_WIDTH = CM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADR_BITS-1:0]   addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADR_BITS];

  // Storage is never reset so contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder: answers a held line request with four single-cycle ack beats.
module cache_mem_responder
  import cache_mem_responder_pkg::*;
#(
  parameter int unsigned ADR_WIDTH    = CM_ADR_WIDTH,
  parameter int unsigned DATA_WIDTH   = CM_DATA_WIDTH,
  parameter int unsigned WORD_OFFSET  = CM_WORD_OFFSET,
  parameter int unsigned MEM_ADR_BITS = 10,
  parameter int unsigned FIRST_LAT    = 3,
  parameter int unsigned BEAT_GAP     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_req_i,
  input  logic [ADR_WIDTH-1:0]   mem_adr_i,
  input  logic                   mem_rdwr_i,
  input  logic [DATA_WIDTH-1:0]  mem_dat_i,
  output logic                   mem_ack_o,
  output logic [DATA_WIDTH-1:0]  mem_dat_o,
  output logic [WORD_OFFSET-1:0] mem_word_o,
  output logic                   busy_o
);

  localparam int unsigned BYTE_BITS = $clog2(DATA_WIDTH / 8);
  localparam int unsigned LINE_BITS = MEM_ADR_BITS - WORD_OFFSET;
  localparam int unsigned CNT_MAX   = (FIRST_LAT > BEAT_GAP) ? FIRST_LAT : BEAT_GAP;
  localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]       WAIT_LOAD = CNT_W'(FIRST_LAT - 1);
  localparam logic [CNT_W-1:0]       GAP_LOAD  = CNT_W'((BEAT_GAP > 0) ? BEAT_GAP - 1 : 0);
  localparam logic [WORD_OFFSET-1:0] LAST_WORD = '1;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [LINE_BITS-1:0]     line;
  logic                     rdwr;
  logic [WORD_OFFSET-1:0]   word;
  logic                     ack;
  logic                     busy;

  logic                     fire;
  logic [WORD_OFFSET-1:0]   fire_word;
  logic [MEM_ADR_BITS-1:0]  ram_addr;
  logic                     ram_we;
  logic                     ram_re;

  logic                     unused_adr;
  assign unused_adr = ^{mem_adr_i[ADR_WIDTH-1:MEM_ADR_BITS+BYTE_BITS],
                        mem_adr_i[WORD_OFFSET+BYTE_BITS-1:0]};

  // fire marks the edge that raises an ack; the RAM access for that beat is
  // issued on the same edge so read data lands together with the ack.
  always_comb begin
    fire      = 1'b0;
    fire_word = word + WORD_OFFSET'(1);
    case (state)
      S_WAIT: begin
        fire      = mem_req_i && (cnt == '0);
        fire_word = '0;
      end
      S_GAP:  fire = mem_req_i && (cnt == '0);
      S_BEAT: fire = mem_req_i && (BEAT_GAP == 0) && (word != LAST_WORD);
      default: ;
    endcase
  end

  assign ram_addr = {line, fire_word};
  assign ram_we   = fire && rdwr;
  assign ram_re   = fire && !rdwr;

  cache_mem_array #(
    .ADR_BITS   (MEM_ADR_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk   (clk),
    .rst_n (rst),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (mem_dat_i),
    .rdata (mem_dat_o)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      line  <= '0;
      rdwr  <= 1'b0;
      word  <= '0;
      ack   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_req_i) begin
            line  <= mem_adr_i[MEM_ADR_BITS+BYTE_BITS-1:WORD_OFFSET+BYTE_BITS];
            rdwr  <= mem_rdwr_i;
            cnt   <= WAIT_LOAD;
            word  <= '0;
            busy  <= 1'b1;
            state <= S_WAIT;
          end
        end
        S_WAIT, S_GAP: begin
          if (!mem_req_i) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (fire) begin
            ack   <= 1'b1;
            word  <= fire_word;
            state <= S_BEAT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_BEAT: begin
          if (!mem_req_i) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (fire) begin
            ack  <= 1'b1;
            word <= fire_word;
          end else if (word == LAST_WORD) begin
            state <= S_DONE;
          end else begin
            cnt   <= GAP_LOAD;
            state <= S_GAP;
          end
        end
        S_DONE: begin
          if (!mem_req_i) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_ack_o  = ack;
  assign mem_word_o = word;
  assign busy_o     = busy;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench: directed burst table, reset-mid-burst sequence and random bursts vs a line-memory model.
module tb_cache_mem_responder;

  localparam int unsigned FL = 3;
  localparam int unsigned G  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_i = 1'b0;
  logic [31:0] mem_adr_i = '0;
  logic        mem_rdwr_i = 1'b0;
  logic [31:0] mem_dat_i = '0;
  logic        mem_ack_o;
  logic [31:0] mem_dat_o;
  logic [1:0]  mem_word_o;
  logic        busy_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] ref_mem [1024];
  bit          known   [1024];

  cache_mem_responder #(
    .ADR_WIDTH    (32),
    .DATA_WIDTH   (32),
    .WORD_OFFSET  (2),
    .MEM_ADR_BITS (10),
    .FIRST_LAT    (FL),
    .BEAT_GAP     (G)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req_i  (mem_req_i),
    .mem_adr_i  (mem_adr_i),
    .mem_rdwr_i (mem_rdwr_i),
    .mem_dat_i  (mem_dat_i),
    .mem_ack_o  (mem_ack_o),
    .mem_dat_o  (mem_dat_o),
    .mem_word_o (mem_word_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected simulation to finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0]          adr;
    logic                 rdwr;
    logic [0:3][31:0]     w;
    int unsigned          nacks;
    int unsigned          hold;
    logic [0:3][31:0]     exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned line_base(input logic [31:0] adr);
    return ((adr >> 2) % 1024) & ~32'd3;
  endfunction

  // One line request: ack k expected FL + k*(G+1) edges after request sampling.
  task automatic burst(input logic [31:0] adr, input logic rdwr, input logic [0:3][31:0] w,
                       input int unsigned nacks, input int unsigned hold,
                       input logic [0:3][31:0] exp, input logic [3:0] chk);
    int unsigned b, k, last_n, n_end, drop_n;
    logic        exp_ack;
    b      = line_base(adr);
    k      = 0;
    last_n = FL + (nacks - 1) * (G + 1);
    n_end  = last_n + hold;
    drop_n = n_end + 10;
    mem_adr_i  = adr;
    mem_rdwr_i = rdwr;
    mem_dat_i  = w[0];
    mem_req_i  = 1'b1;
    tick();
    check("busy_start", busy_o, 1'b1);
    mem_adr_i  = $urandom();
    mem_rdwr_i = ~rdwr;
    for (int unsigned n = 0; n <= n_end; n++) begin
      exp_ack = (n >= FL) && ((n - FL) % (G + 1) == 0) && ((n - FL) / (G + 1) < nacks);
      check("ack", mem_ack_o, exp_ack);
      if (n == drop_n + 1) begin
        check("busy_abort", busy_o, 1'b0);
      end
      if (exp_ack) begin
        check("word", mem_word_o, 32'(k));
        if (rdwr) begin
          ref_mem[b + k] = w[k];
          known[b + k]   = 1'b1;
        end else if (chk[k]) begin
          check("rdata", mem_dat_o, exp[k]);
        end
        k++;
        if (k < 4) mem_dat_i = w[k];
        if (k == nacks && nacks < 4) begin
          mem_req_i = 1'b0;
          drop_n    = n;
        end
      end
      if (n < n_end) tick();
    end
    if (nacks == 4) check("busy_done", busy_o, 1'b1);
    if (!rdwr && chk[nacks-1]) check("rdata_hold", mem_dat_o, exp[nacks-1]);
    mem_req_i = 1'b0;
    tick();
    check("busy_idle", busy_o, 1'b0);
    check("ack_idle", mem_ack_o, 1'b0);
  endtask

  localparam logic [31:0] W0 = 32'h75CCD4A5, W1 = 32'h75CCD4BD, W2 = 32'h75CCB4A5, W3 = 32'h75C0D4A5;
  localparam logic [31:0] X0 = 32'h11111111, X1 = 32'h22222222, X2 = 32'h33333333, X3 = 32'h44444444;
  localparam logic [31:0] N0 = 32'hA0A0A0A0, N1 = 32'hB1B1B1B1, N2 = 32'hC2C2C2C2, N3 = 32'hD3D3D3D3;

  initial begin
    vec_t             vecs[6];
    logic [7:0]       lines[4];
    logic [0:3][31:0] nw, exp, w;
    logic [3:0]       chk;
    logic [31:0]      adr;
    logic             rdwr, exp_ack;
    int unsigned      b, nacks, hold;

    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = '0;
      known[i]   = 1'b0;
    end
    lines[0] = 8'hB4; lines[1] = 8'h34; lines[2] = 8'h10; lines[3] = 8'h11;

    vecs[0] = '{adr: 32'h00CC3B40, rdwr: 1'b1, w: {W0, W1, W2, W3}, nacks: 4, hold: 30, exp: '0};
    vecs[1] = '{adr: 32'h00CC3B43, rdwr: 1'b0, w: '0, nacks: 4, hold: 3, exp: {W0, W1, W2, W3}};
    vecs[2] = '{adr: 32'h00CC3B40, rdwr: 1'b0, w: '0, nacks: 2, hold: 8, exp: {W0, W1, W2, W3}};
    vecs[3] = '{adr: 32'h00CC3340, rdwr: 1'b1, w: {X0, X1, X2, X3}, nacks: 4, hold: 2, exp: '0};
    vecs[4] = '{adr: 32'h00CC3B40, rdwr: 1'b0, w: '0, nacks: 4, hold: 2, exp: {W0, W1, W2, W3}};
    vecs[5] = '{adr: 32'h00CC334C, rdwr: 1'b0, w: '0, nacks: 4, hold: 1, exp: {X0, X1, X2, X3}};

    rst = 1'b0;
    tick();
    tick();
    check("rst_ack", mem_ack_o, 1'b0);
    check("rst_dat", mem_dat_o, 32'h0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_word", mem_word_o, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_ack", mem_ack_o, 1'b0);
    end
    check("idle_busy", busy_o, 1'b0);

    for (int i = 0; i < 6; i++) begin
      burst(vecs[i].adr, vecs[i].rdwr, vecs[i].w, vecs[i].nacks, vecs[i].hold,
            vecs[i].exp, vecs[i].rdwr ? 4'h0 : 4'hF);
    end

    // Reset asserted while ack 1 of a write is high: beats 0 and 1 stay committed.
    nw = {N0, N1, N2, N3};
    b  = line_base(32'h00CC3B40);
    mem_adr_i = 32'h00CC3B40; mem_rdwr_i = 1'b1; mem_dat_i = nw[0]; mem_req_i = 1'b1;
    tick();
    for (int unsigned n = 0; n <= 7; n++) begin
      exp_ack = (n == 3) || (n == 7);
      check("rstseq_ack", mem_ack_o, exp_ack);
      if (exp_ack) begin
        ref_mem[b + n / 4] = nw[n / 4];
        mem_dat_i = nw[n / 4 + 1];
      end
      if (n < 7) tick();
    end
    #1 rst = 1'b0;
    #1;
    check("rstseq_ack_drop", mem_ack_o, 1'b0);
    check("rstseq_busy", busy_o, 1'b0);
    check("rstseq_dat", mem_dat_o, 32'h0);
    mem_req_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    burst(32'h00CC3B48, 1'b0, '0, 4, 2, {N0, N1, W2, W3}, 4'hF);

    for (int i = 0; i < 16; i++) begin
      adr   = ($urandom() & 32'hFFFF_F000) | (32'(lines[$urandom_range(0, 3)]) << 4)
              | 32'($urandom_range(0, 15));
      rdwr  = 1'($urandom_range(0, 1));
      nacks = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 4;
      hold  = $urandom_range(1, 5);
      b     = line_base(adr);
      for (int k = 0; k < 4; k++) begin
        w[k]   = $urandom();
        exp[k] = ref_mem[b + 32'(k)];
        chk[k] = known[b + 32'(k)];
      end
      burst(adr, rdwr, w, nacks, hold, exp, chk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
